// File: rtl/skinny_sbox_drv_pkg.sv
// Shared types and constants for the masked Skinny S-box driver.
// The LFSR constants are only used when SKINNY_DRIVER_LFSR_EN is defined.
package skinny_sbox_drv_pkg;

    localparam int LATENCY_DEF = 11;
    localparam int FRESH_W_DEF = 13;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } drv_state_e;

    // Maximal-length 13-bit Fibonacci polynomial x^13 + x^4 + x^3 + x + 1
    localparam logic [12:0] LFSR_SEED = 13'h1ACE;
    localparam logic [12:0] LFSR_TAPS = 13'b1_0000_0000_1101;

endpackage

// File: rtl/skinny_fresh_lfsr.sv
// Enable-stepped Fibonacci LFSR supplying fresh randomness to the masked S-box.
// Instantiated by the driver only when SKINNY_DRIVER_LFSR_EN is defined.
module skinny_fresh_lfsr
    import skinny_sbox_drv_pkg::*;
#(
    parameter int             W    = FRESH_W_DEF,
    parameter logic [W-1:0]   SEED = W'(LFSR_SEED),
    parameter logic [W-1:0]   TAPS = W'(LFSR_TAPS)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         step_i,
    output logic [W-1:0] state_o
);

    logic [W-1:0] state_q;
    logic [W-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (step_i) begin
            state_d = {state_q[W-2:0], ^(state_q & TAPS)};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/skinny_sbox_masked_driver.sv
// Initiator for the clock-gated 2-share Skinny S-box Synch handshake.
// Define SKINNY_DRIVER_LFSR_EN to source sb_fresh from an internal LFSR instead of rnd_in.
module skinny_sbox_masked_driver
    import skinny_sbox_drv_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEF,
    parameter int FRESH_W = FRESH_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_s0,
    input  logic [3:0]         in_s1,
    input  logic [FRESH_W-1:0] rnd_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_s0,
    output logic [3:0]         out_s1,
    output logic               err,
    output logic               sb_rst,
    output logic [3:0]         sb_si_s0,
    output logic [3:0]         sb_si_s1,
    output logic [FRESH_W-1:0] sb_fresh,
    input  logic [3:0]         sb_so_s0,
    input  logic [3:0]         sb_so_s1,
    input  logic               sb_synch
);

    localparam int               CNT_MAX = (TIMEOUT > LATENCY) ? TIMEOUT : LATENCY;
    localparam int               CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);

    drv_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               synch_q, synch_d;
    logic [3:0]         si0_q, si0_d;
    logic [3:0]         si1_q, si1_d;
    logic [FRESH_W-1:0] fresh_q, fresh_d;
    logic [3:0]         out0_q, out0_d;
    logic [3:0]         out1_q, out1_d;
    logic               err_q, err_d;
    logic               rdy_q;
    logic               accept;
    logic [FRESH_W-1:0] fresh_src;

    assign accept = in_valid && in_ready;

`ifdef SKINNY_DRIVER_LFSR_EN
    logic [FRESH_W-1:0] lfsr_state;
    logic               unused_rnd;

    skinny_fresh_lfsr #(
        .W    (FRESH_W),
        .SEED (FRESH_W'(LFSR_SEED)),
        .TAPS (FRESH_W'(LFSR_TAPS))
    ) u_lfsr (
        .clk_i   (clk),
        .rst_i   (rst),
        .step_i  (accept),
        .state_o (lfsr_state)
    );

    assign fresh_src  = lfsr_state;
    assign unused_rnd = ^rnd_in;
`else
    assign fresh_src = rnd_in;
`endif

    assign cnt_inc = (cnt_q == CNT_TO) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        synch_d = synch_q;
        si0_d   = si0_q;
        si1_d   = si1_q;
        fresh_d = fresh_q;
        out0_d  = out0_q;
        out1_d  = out1_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    si0_d   = in_s0;
                    si1_d   = in_s1;
                    fresh_d = fresh_src;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                synch_d = 1'b0;
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_inc;
                // S-box output regs move on the gated edge coinciding with Synch,
                // so the shares are only valid one cycle after Synch is seen.
                if (synch_q) begin
                    out0_d  = sb_so_s0;
                    out1_d  = sb_so_s1;
                    state_d = DONE;
                end else if (cnt_inc == CNT_TO) begin
                    err_d   = 1'b1;
                    out0_d  = 4'h0;
                    out1_d  = 4'h0;
                    state_d = DONE;
                end else if (sb_synch) begin
                    synch_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            synch_q <= 1'b0;
            si0_q   <= 4'h0;
            si1_q   <= 4'h0;
            fresh_q <= '0;
            out0_q  <= 4'h0;
            out1_q  <= 4'h0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            synch_q <= synch_d;
            si0_q   <= si0_d;
            si1_q   <= si1_d;
            fresh_q <= fresh_d;
            out0_q  <= out0_d;
            out1_q  <= out1_d;
            err_q   <= err_d;
            rdy_q   <= 1'b1;
        end
    end

    assign in_ready  = (state_q == IDLE) && rdy_q;
    assign out_valid = (state_q == DONE);
    assign sb_rst    = (state_q != RUN);
    assign out_s0    = out0_q;
    assign out_s1    = out1_q;
    assign err       = err_q;
    assign sb_si_s0  = si0_q;
    assign sb_si_s1  = si1_q;
    assign sb_fresh  = fresh_q;

endmodule

// File: tb/tb_skinny_sbox_masked_driver.sv
// Directed bench for skinny_sbox_masked_driver with a behavioural gated S-box model.
// Honours SKINNY_DRIVER_LFSR_EN for the fresh-randomness expectations.
module tb_skinny_sbox_masked_driver;

    localparam int LAT = 11;
    localparam int FW  = 13;
    localparam int TO  = 16;
    localparam logic [3:0] MASK = 4'h6;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_s0, in_s1;
    logic [FW-1:0] rnd_in;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_s0, out_s1;
    logic          err;
    logic          sb_rst;
    logic [3:0]    sb_si_s0, sb_si_s1;
    logic [FW-1:0] sb_fresh;
    logic [3:0]    sb_so_s0, sb_so_s1;
    logic          sb_synch;

    int tests = 0;
    int fails = 0;

    skinny_sbox_masked_driver #(.LATENCY(LAT), .FRESH_W(FW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_s0(in_s0), .in_s1(in_s1), .rnd_in(rnd_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s0(out_s0), .out_s1(out_s1), .err(err),
        .sb_rst(sb_rst), .sb_si_s0(sb_si_s0), .sb_si_s1(sb_si_s1),
        .sb_fresh(sb_fresh), .sb_so_s0(sb_so_s0), .sb_so_s1(sb_so_s1),
        .sb_synch(sb_synch)
    );

    always #5 clk = ~clk;

    // Skinny-64 4-bit S-box
    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'hC; 4'h1: sbox = 4'h6; 4'h2: sbox = 4'h9; 4'h3: sbox = 4'h0;
            4'h4: sbox = 4'h1; 4'h5: sbox = 4'hA; 4'h6: sbox = 4'h2; 4'h7: sbox = 4'hB;
            4'h8: sbox = 4'h3; 4'h9: sbox = 4'h8; 4'hA: sbox = 4'h5; 4'hB: sbox = 4'hD;
            4'hC: sbox = 4'h4; 4'hD: sbox = 4'hE; 4'hE: sbox = 4'h7; default: sbox = 4'hF;
        endcase
    endfunction

    // Gated S-box model: Synch is sampled LATENCY edges after sb_rst falls
    logic [7:0] mcnt = 8'd0;
    logic       synch_en = 1'b1;
    logic       force_synch = 1'b0;
    logic [3:0] so0 = 4'h0, so1 = 4'h0;

    assign sb_synch = (!sb_rst && synch_en && (mcnt == 8'(LAT - 1))) || force_synch;
    assign sb_so_s0 = so0;
    assign sb_so_s1 = so1;

    always @(posedge clk) begin
        if (sb_rst) mcnt <= 8'd0;
        else        mcnt <= mcnt + 8'd1;
        if (!sb_rst && sb_synch) begin
            so0 <= MASK;
            so1 <= sbox(sb_si_s0 ^ sb_si_s1) ^ MASK;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Handshake one nibble, then wait for out_valid while scrambling the inputs.
    // n = edges after the handshake edge until out_valid is seen.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [FW-1:0] r,
                          input logic [FW-1:0] lfsr_exp, input int opno, output int n);
        logic [FW-1:0] f0;
        in_s0 = a; in_s1 = b; rnd_in = r; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("load_si0", sb_si_s0, a);
        chk("load_si1", sb_si_s1, b);
`ifdef SKINNY_DRIVER_LFSR_EN
        if (opno <= 2) chk("load_fresh_lfsr", sb_fresh, lfsr_exp);
`else
        chk("load_fresh", sb_fresh, r);
`endif
        chk("load_in_ready", in_ready, 1'b0);
        chk("load_sb_rst", sb_rst, 1'b1);
        f0 = sb_fresh;
        n = 0;
        while (!out_valid && n < 40) begin
            in_s0 = 4'($urandom); in_s1 = 4'($urandom); rnd_in = FW'($urandom);
            tick();
            n++;
            chk("stable_si0", sb_si_s0, a);
            chk("stable_si1", sb_si_s1, b);
            chk("stable_fresh", sb_fresh, f0);
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int n, t, h1, h2;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_s0 = 4'h0; in_s1 = 4'h0; rnd_in = '0;
        tick(); tick();
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_s0", out_s0, 4'h0);
        chk("rst_out_s1", out_s1, 4'h0);
        chk("rst_err", err, 1'b0);
        chk("rst_sb_rst", sb_rst, 1'b1);
        chk("rst_sb_si0", sb_si_s0, 4'h0);
        chk("rst_sb_fresh", sb_fresh, 13'h0);
        rst = 1'b0;
        tick();
        chk("idle_in_ready", in_ready, 1'b1);

        // Nominal: 5^A = F, S(F) = F
        run_op(4'h5, 4'hA, 13'h0B3C, 13'h1ACE, 1, n);
        chk("nom_latency", n, LAT + 2);
        chk("nom_out_valid", out_valid, 1'b1);
        chk("nom_out_s0", out_s0, 4'h6);
        chk("nom_out_s1", out_s1, 4'h9);
        chk("nom_unmasked", out_s0 ^ out_s1, 4'hF);
        chk("nom_err", err, 1'b0);
        chk("nom_done_sb_rst", sb_rst, 1'b1);
        drain();
        chk("nom_exit_valid", out_valid, 1'b0);
        chk("nom_exit_ready", in_ready, 1'b1);

        // Backpressure: 1^1 = 0, S(0) = C
        run_op(4'h1, 4'h1, 13'h1234, 13'h159D, 2, n);
        chk("bp_latency", n, LAT + 2);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_out_s0", out_s0, 4'h6);
            chk("bp_out_s1", out_s1, 4'hA);
            chk("bp_in_ready", in_ready, 1'b0);
        end
        drain();
        chk("bp_exit_valid", out_valid, 1'b0);
        chk("bp_exit_ready", in_ready, 1'b1);
        // New input after release: 2^0 = 2, S(2) = 9
        run_op(4'h2, 4'h0, 13'h0F0F, 13'h0, 3, n);
        chk("bp_next_latency", n, LAT + 2);
        chk("bp_next_out_s1", out_s1, 4'hF);
        drain();

        // Throughput with out_ready tied high
        out_ready = 1'b1; in_s0 = 4'h5; in_s1 = 4'hA; in_valid = 1'b1;
        t = 0; h1 = -1; h2 = -1;
        while (h2 < 0 && t < 60) begin
            if (in_ready) begin
                if (h1 < 0) h1 = t;
                else        h2 = t;
            end
            tick();
            t++;
        end
        in_valid = 1'b0;
        chk("thr_period", h2 - h1, LAT + 4);
        t = 0;
        while (!in_ready && t < 40) begin
            tick();
            t++;
        end
        chk("thr_back_idle", in_ready, 1'b1);
        out_ready = 1'b0;

        // Timeout: model never raises Synch
        synch_en = 1'b0;
        run_op(4'h4, 4'h4, 13'h0AAA, 13'h0, 4, n);
        chk("to_latency", n, TO + 1);
        chk("to_err", err, 1'b1);
        chk("to_out_valid", out_valid, 1'b1);
        chk("to_out_s0", out_s0, 4'h0);
        chk("to_out_s1", out_s1, 4'h0);
        drain();
        chk("to_err_idle", err, 1'b1);
        synch_en = 1'b1;
        // Sticky err over a good op: 3^0 = 3, S(3) = 0
        run_op(4'h3, 4'h0, 13'h0555, 13'h0, 5, n);
        chk("sticky_latency", n, LAT + 2);
        chk("sticky_out_s1", out_s1, 4'h6);
        chk("sticky_err", err, 1'b1);
        drain();

        // Reset during RUN cycle 5
        in_s0 = 4'h7; in_s1 = 4'h0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_run_sb_rst", sb_rst, 1'b0);
        rst = 1'b1;
        tick();
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_sb_rst", sb_rst, 1'b1);
        chk("mid_rst_err", err, 1'b0);
        chk("mid_rst_sb_si0", sb_si_s0, 4'h0);
        rst = 1'b0;
        tick();
        chk("mid_rst_in_ready", in_ready, 1'b1);
        force_synch = 1'b1;
        tick();
        force_synch = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("ign_synch_valid", out_valid, 1'b0);
        chk("ign_synch_ready", in_ready, 1'b1);
        chk("ign_synch_out_s0", out_s0, 4'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
